// File: rtl/mem_access_pkg.sv
// Shared encodings for the byte/half/word memory access controller and its RAM.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } state_e;

  // Illegal size, or an access that straddles its natural alignment.
  function automatic logic req_illegal(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: req_illegal = 1'b0;
      SZ_HALF: req_illegal = off[0];
      SZ_WORD: req_illegal = (off != 2'b00);
      default: req_illegal = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane extraction with sign/zero extension, and sub-word merge into an old word.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] ext_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word_i[7:0];
    case (offset_i)
      2'd0:    byte_v = word_i[7:0];
      2'd1:    byte_v = word_i[15:8];
      2'd2:    byte_v = word_i[23:16];
      default: byte_v = word_i[31:24];
    endcase
    half_v = offset_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    ext_o = word_i;
    case (size_i)
      SZ_BYTE: ext_o = {{24{signed_i & byte_v[7]}}, byte_v};
      SZ_HALF: ext_o = {{16{signed_i & half_v[15]}}, half_v};
      default: ext_o = word_i;
    endcase
  end

  always_comb begin
    merge_o = word_i;
    case (size_i)
      SZ_BYTE: begin
        case (offset_i)
          2'd0:    merge_o[7:0]   = wdata_i[7:0];
          2'd1:    merge_o[15:8]  = wdata_i[7:0];
          2'd2:    merge_o[23:16] = wdata_i[7:0];
          default: merge_o[31:24] = wdata_i[7:0];
        endcase
      end
      SZ_HALF: begin
        if (offset_i[1]) merge_o[31:16] = wdata_i[15:0];
        else             merge_o[15:0]  = wdata_i[15:0];
      end
      default: merge_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store initiator for a word-wide single-port RAM; sub-word stores use read-modify-write.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [AW+1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rw,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  // A request transfers on a rising edge with req_valid && req_ready; ready is only
  // offered in IDLE, and the response is a single unthrottled resp_valid pulse.
  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    off_q, off_d;
  logic [1:0]    size_q, size_d;
  logic          we_q, we_d;
  logic          signed_q, signed_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;

  logic          accept;
  logic [DW-1:0] ext_word;
  logic [DW-1:0] merged_word;

  mem_lane_align u_align (
    .word_i   (mem_rdata),
    .wdata_i  (wdata_q),
    .offset_i (off_q),
    .size_i   (size_q),
    .signed_i (signed_q),
    .ext_o    (ext_word),
    .merge_o  (merged_word)
  );

  assign req_ready  = rstn && (state_q == IDLE);
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_addr   = addr_q;
  assign mem_rw     = (state_q == WRITE) ? RW_WRITE : RW_READ;
  assign mem_wdata  = mem_wdata_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    off_d       = off_q;
    size_d      = size_q;
    we_d        = we_q;
    signed_d    = signed_q;
    wdata_d     = wdata_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d   = req_addr[AW+1:2];
          off_d    = req_addr[1:0];
          size_d   = req_size;
          we_d     = req_we;
          signed_d = req_signed;
          wdata_d  = req_wdata;
          if (req_illegal(req_size, req_addr[1:0])) begin
            state_d = RESP;
            rdata_d = '0;
            err_d   = 1'b1;
          end else if (req_we && (req_size == SZ_WORD)) begin
            state_d     = WRITE;
            mem_wdata_d = req_wdata;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (we_q) begin
          state_d     = WRITE;
          mem_wdata_d = merged_word;
        end else begin
          state_d = RESP;
          rdata_d = ext_word;
          err_d   = 1'b0;
        end
      end
      WRITE: begin
        state_d = RESP;
        rdata_d = '0;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      off_q       <= '0;
      size_q      <= SZ_BYTE;
      we_q        <= 1'b0;
      signed_q    <= 1'b0;
      wdata_q     <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      off_q       <= off_d;
      size_q      <= size_d;
      we_q        <= we_d;
      signed_q    <= signed_d;
      wdata_q     <= wdata_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized scoreboard bench for mem_access_ctrl against a byte-array memory model.
module tb_mem_access_ctrl;
  import mem_access_pkg::*;

  localparam int AW = 4;
  localparam int DW = 32;

  logic          clk;
  logic          rstn;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [AW+1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic [AW-1:0] mem_addr;
  logic          mem_rw;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  mem_access_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_rw     (mem_rw),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // ---------------- clock / reset / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- RAM attached to the DUT ----------------
  logic [31:0] ram [16];
  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) if (mem_rw == RW_WRITE) ram[mem_addr] = mem_wdata;

  // ---------------- reference model: byte-addressed memory ----------------
  logic [7:0] ref_mem [64];

  function automatic logic [31:0] ref_word(input int i);
    return {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};
  endfunction

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] acc;
    logic [31:0] lat;
  } exp_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [31:0]   at;
  } wr_t;

  exp_t exp_q[$];
  wr_t  wr_q[$];
  exp_t me;
  wr_t  mw;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // ---------------- driver ----------------
  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [5:0] addr, input logic [31:0] wdata);
    int waited;
    int nb;
    int a;
    logic [31:0] v;
    logic [31:0] m;
    waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL req_ready_timeout actual=0 expected=1 (cycle %0d)", cyc);
      return;
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;

    a  = int'(addr);
    nb = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : (size == 2'b10) ? 4 : 0;
    if (nb == 0 || (a % nb) != 0) begin
      exp_q.push_back('{rdata: 32'd0, err: 1'b1, acc: 32'(cyc), lat: 32'd1});
    end else if (!we) begin
      v = 32'd0;
      for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[a+i]) << (8*i));
      m = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nb)) - 32'd1);
      if (sgn && nb < 4 && v[8*nb-1]) v = v | ~m;
      exp_q.push_back('{rdata: v, err: 1'b0, acc: 32'(cyc), lat: 32'd2});
    end else begin
      for (int i = 0; i < nb; i++) ref_mem[a+i] = wdata[8*i +: 8];
      wr_q.push_back('{addr: AW'(a/4), data: ref_word(a/4),
                       at: 32'(cyc + ((nb == 4) ? 1 : 2))});
      exp_q.push_back('{rdata: 32'd0, err: 1'b0, acc: 32'(cyc),
                        lat: (nb == 4) ? 32'd2 : 32'd3});
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wdata = $urandom;
    req_addr  = 6'($urandom_range(0, 63));
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rstn) begin
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL resp_unexpected rdata=%h err=%0b (cycle %0d)", resp_rdata, resp_err, cyc);
        end else begin
          me = exp_q.pop_front();
          chk("resp_rdata", resp_rdata, me.rdata);
          chk("resp_err", {31'd0, resp_err}, {31'd0, me.err});
          chk("resp_latency", 32'(cyc) - me.acc, me.lat);
        end
      end else if (exp_q.size() != 0 && 32'(cyc) > exp_q[0].acc + exp_q[0].lat) begin
        me = exp_q.pop_front();
        checks++;
        failures++;
        $display("FAIL resp_timeout actual=none expected=resp at latency %0d", me.lat);
      end

      if (mem_rw == RW_WRITE) begin
        if (wr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL write_unexpected addr=%h data=%h (cycle %0d)", mem_addr, mem_wdata, cyc);
        end else begin
          mw = wr_q.pop_front();
          chk("write_addr", {28'd0, mem_addr}, {28'd0, mw.addr});
          chk("write_data", mem_wdata, mw.data);
          chk("write_cycle", 32'(cyc), mw.at);
        end
      end else if (wr_q.size() != 0 && 32'(cyc) > wr_q[0].at) begin
        mw = wr_q.pop_front();
        checks++;
        failures++;
        $display("FAIL write_timeout actual=none expected=write addr %h data %h", mw.addr, mw.data);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"},  {31'd0, req_ready},  32'd0);
    chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_mem_rw"},     {31'd0, mem_rw},     32'd1);
  endtask

  initial begin
    logic [31:0] w;
    int waited;
    rstn       = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = SZ_BYTE;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    for (int i = 0; i < 16; i++) begin
      w = (i == 3) ? 32'h8899_AABB : $urandom;
      ram[i] = w;
      for (int b = 0; b < 4; b++) ref_mem[4*i+b] = w[8*b +: 8];
    end

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    chk("reset_resp_rdata", resp_rdata, 32'd0);
    chk("reset_resp_err", {31'd0, resp_err}, 32'd0);
    chk("reset_mem_addr", {28'd0, mem_addr}, 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);
    rstn = 1'b1;
    #1;
    chk("post_reset_ready", {31'd0, req_ready}, 32'd1);

    // directed cases around RAM word 3 = 0x8899AABB
    issue(1'b0, SZ_BYTE, 1'b1, 6'h0D, 32'd0);
    issue(1'b0, SZ_HALF, 1'b0, 6'h0E, 32'd0);
    issue(1'b0, SZ_WORD, 1'b0, 6'h0C, 32'd0);
    issue(1'b1, SZ_BYTE, 1'b0, 6'h0E, 32'hFFFF_FF11);
    issue(1'b0, SZ_WORD, 1'b0, 6'h0C, 32'd0);
    issue(1'b1, SZ_WORD, 1'b0, 6'h04, 32'hDEAD_BEEF);
    issue(1'b0, SZ_WORD, 1'b0, 6'h04, 32'd0);
    issue(1'b0, SZ_WORD, 1'b0, 6'h06, 32'd0);
    issue(1'b1, SZ_HALF, 1'b0, 6'h03, 32'h0000_1234);
    issue(1'b0, 2'b11,   1'b0, 6'h00, 32'd0);
    issue(1'b1, 2'b11,   1'b0, 6'h08, 32'h5555_5555);
    issue(1'b1, SZ_HALF, 1'b0, 6'h22, 32'h0000_8001);
    issue(1'b0, SZ_HALF, 1'b1, 6'h22, 32'd0);
    issue(1'b0, SZ_BYTE, 1'b0, 6'h3F, 32'd0);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            6'($urandom_range(0, 63)), $urandom);
    end

    // reset during the READ of a sub-word store: no write, no response
    waited = 0;
    @(negedge clk);
    while ((!req_ready || exp_q.size() != 0) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = SZ_BYTE;
    req_addr  = 6'h0E;
    req_wdata = 32'h0000_0077;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (2) @(negedge clk);
    check_reset_outputs("abort_hold");
    rstn = 1'b1;
    @(negedge clk);
    chk("abort_ready_after", {31'd0, req_ready}, 32'd1);
    chk("abort_resp_err", {31'd0, resp_err}, 32'd0);
    chk("abort_ram_word3", ram[3], ref_word(3));

    // a load after the abort still sees the untouched word
    issue(1'b0, SZ_WORD, 1'b0, 6'h0C, 32'd0);

    waited = 0;
    while ((exp_q.size() != 0 || wr_q.size() != 0) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    repeat (2) @(negedge clk);
    chk("resp_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("write_queue_drained", 32'(wr_q.size()), 32'd0);
    for (int i = 0; i < 16; i++) chk($sformatf("ram_word_%0d", i), ram[i], ref_word(i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
